// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin arbiter sharing one cache CPU port between fetch and LSU
//
// Purpose:
//   Accepts one transaction at a time from master 0 (instruction fetch) or
//   master 1 (load/store unit). The accepted request is latched and presented
//   on the cache port with a valid/ready handshake. The cache response is then
//   routed back to the owning master. Priority only matters when both masters
//   request in the same cycle; it alternates after every completed transaction.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   mN_valid_i/mN_ready_o  master N request handshake (ready is combinational in IDLE)
//   mN_we_i/adr_i/wdata_i  master N request fields
//   mN_rdata_o             broadcast of cache_rdata_i
//   mN_resp_valid_o        response pulse for master N (combinational from cache_resp_valid_i)
//   cache_valid_o/ready_i  request handshake towards the cache
//   cache_we/adr/wdata_o   latched request fields, stable while cache_valid_o is high
//   cache_rdata_i          cache response data
//   cache_resp_valid_i     cache response pulse, one per accepted request
//   busy_o                 a transaction is in flight
//   owner_o                master owning the in-flight transaction (valid while busy_o)

module cache_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_resp_valid_o,

    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_resp_valid_o,

    output logic                  cache_valid_o,
    input  logic                  cache_ready_i,
    output logic                  cache_we_o,
    output logic [ADDR_WIDTH-1:0] cache_adr_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    input  logic [DATA_WIDTH-1:0] cache_rdata_i,
    input  logic                  cache_resp_valid_i,

    output logic                  busy_o,
    output logic                  owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic                    owner_q, owner_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    any_valid;
    logic                    winner;
    logic                    accept;
    logic                    resp_fire;

    // Winner selection: a lone requester always wins; the priority pointer
    // only breaks ties between simultaneous requests.
    always_comb begin
        any_valid = m0_valid_i | m1_valid_i;
        if (m0_valid_i && m1_valid_i) begin
            winner = prio_q;
        end else begin
            winner = m1_valid_i;
        end
    end

    assign accept = (state_q == ST_IDLE) && any_valid;

    // A response is only meaningful once the cache has taken the request:
    // either in WAIT, or in REQ when ready and response coincide (zero-latency
    // hit). Anything else is a stray pulse and is dropped.
    assign resp_fire = ((state_q == ST_REQ)  && cache_ready_i && cache_resp_valid_i) ||
                       ((state_q == ST_WAIT) && cache_resp_valid_i);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    owner_d = winner;
                    we_d    = winner ? m1_we_i    : m0_we_i;
                    adr_d   = winner ? m1_adr_i   : m0_adr_i;
                    wdata_d = winner ? m1_wdata_i : m0_wdata_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cache_ready_i) begin
                    state_d = cache_resp_valid_i ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cache_resp_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Rotate on completion so the other master wins the next tie.
        if (resp_fire) begin
            prio_d = ~owner_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
        end
    end

    // Master-side outputs
    assign m0_ready_o      = accept && !winner;
    assign m1_ready_o      = accept &&  winner;
    assign m0_rdata_o      = cache_rdata_i;
    assign m1_rdata_o      = cache_rdata_i;
    assign m0_resp_valid_o = resp_fire && !owner_q;
    assign m1_resp_valid_o = resp_fire &&  owner_q;

    // Cache-side outputs come straight from state and latched fields, so they
    // cannot glitch with master inputs while the request is pending.
    assign cache_valid_o   = (state_q == ST_REQ);
    assign cache_we_o      = we_q;
    assign cache_adr_o     = adr_q;
    assign cache_wdata_o   = wdata_q;

    assign busy_o          = (state_q != ST_IDLE);
    assign owner_o         = owner_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - scoreboard bench for cache_port_arbiter

module tb_cache_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid_i, m0_ready_o, m0_we_i, m0_resp_valid_o;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_wdata_i, m0_rdata_o;
    logic          m1_valid_i, m1_ready_o, m1_we_i, m1_resp_valid_o;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_wdata_i, m1_rdata_o;
    logic          cache_valid_o, cache_ready_i, cache_we_o, cache_resp_valid_i;
    logic [AW-1:0] cache_adr_o;
    logic [DW-1:0] cache_wdata_o, cache_rdata_i;
    logic          busy_o, owner_o;

    always #5 clk = ~clk;

    cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .m0_valid_i         (m0_valid_i),
        .m0_ready_o         (m0_ready_o),
        .m0_we_i            (m0_we_i),
        .m0_adr_i           (m0_adr_i),
        .m0_wdata_i         (m0_wdata_i),
        .m0_rdata_o         (m0_rdata_o),
        .m0_resp_valid_o    (m0_resp_valid_o),
        .m1_valid_i         (m1_valid_i),
        .m1_ready_o         (m1_ready_o),
        .m1_we_i            (m1_we_i),
        .m1_adr_i           (m1_adr_i),
        .m1_wdata_i         (m1_wdata_i),
        .m1_rdata_o         (m1_rdata_o),
        .m1_resp_valid_o    (m1_resp_valid_o),
        .cache_valid_o      (cache_valid_o),
        .cache_ready_i      (cache_ready_i),
        .cache_we_o         (cache_we_o),
        .cache_adr_o        (cache_adr_o),
        .cache_wdata_o      (cache_wdata_o),
        .cache_rdata_i      (cache_rdata_i),
        .cache_resp_valid_i (cache_resp_valid_i),
        .busy_o             (busy_o),
        .owner_o            (owner_o)
    );

    typedef struct {
        logic          owner;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
    } rsp_t;

    logic exp_grant[$];
    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int   checks = 0;
    int   errors = 0;
    logic prio_m;   // reference priority pointer: who wins the next tie

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output seen with no expectation queued at %0t", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake.
    always @(negedge clk) begin
        if (m0_ready_o || m1_ready_o) begin
            check("ready_onehot", {63'd0, m0_ready_o & m1_ready_o}, 64'd0);
            if (exp_grant.size() == 0) flag("unexpected_grant");
            else check("grant_master", {63'd0, m1_ready_o}, {63'd0, exp_grant.pop_front()});
        end
        if (cache_valid_o && cache_ready_i) begin
            if (exp_req.size() == 0) begin
                flag("unexpected_cache_req");
            end else begin
                req_t r;
                r = exp_req.pop_front();
                check("req_owner", {63'd0, owner_o},    {63'd0, r.owner});
                check("req_we",    {63'd0, cache_we_o}, {63'd0, r.we});
                check("req_adr",   {48'd0, cache_adr_o}, {48'd0, r.adr});
                check("req_wdata", {32'd0, cache_wdata_o}, {32'd0, r.wdata});
            end
        end
        if (m0_resp_valid_o || m1_resp_valid_o) begin
            check("resp_onehot", {63'd0, m0_resp_valid_o & m1_resp_valid_o}, 64'd0);
            if (exp_rsp.size() == 0) begin
                flag("unexpected_resp");
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                check("resp_master", {63'd0, m1_resp_valid_o}, {63'd0, e.owner});
                check("resp_data0",  {32'd0, m0_rdata_o}, {32'd0, e.data});
                check("resp_data1",  {32'd0, m1_rdata_o}, {32'd0, e.data});
            end
        end
    end

    function automatic req_t rand_req();
        req_t r;
        r.owner = 1'b0;
        r.we    = 1'($urandom_range(0, 1));
        r.adr   = AW'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    // One complete transaction. Entered and left just after a rising edge with
    // the DUT idle. bp = cycles of cache backpressure, lat < 0 = zero-latency
    // hit, otherwise idle WAIT cycles before the response.
    task automatic do_txn(input logic v0, input logic v1, input req_t r0, input req_t r1,
                          input int bp, input int lat, input logic [DW-1:0] rdata,
                          input bit rst_in_wait);
        logic win;
        req_t w;
        rsp_t e;
        win     = (v0 && v1) ? prio_m : v1;
        w       = win ? r1 : r0;
        w.owner = win;

        m0_valid_i = v0; m0_we_i = r0.we; m0_adr_i = r0.adr; m0_wdata_i = r0.wdata;
        m1_valid_i = v1; m1_we_i = r1.we; m1_adr_i = r1.adr; m1_wdata_i = r1.wdata;
        exp_grant.push_back(win);
        exp_req.push_back(w);
        @(posedge clk); #1;
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        check("busy_after_accept", {63'd0, busy_o}, 64'd1);
        check("cache_valid_after_accept", {63'd0, cache_valid_o}, 64'd1);

        for (int i = 0; i < bp; i++) begin
            cache_ready_i      = 1'b0;
            cache_resp_valid_i = 1'($urandom_range(0, 1));   // stray, must be ignored
            cache_rdata_i      = $urandom;
            m0_valid_i         = 1'($urandom_range(0, 1));
            m1_valid_i         = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_valid", {63'd0, cache_valid_o}, 64'd1);
            check("bp_adr",   {48'd0, cache_adr_o},   {48'd0, w.adr});
            check("bp_we",    {63'd0, cache_we_o},    {63'd0, w.we});
            check("bp_wdata", {32'd0, cache_wdata_o}, {32'd0, w.wdata});
            check("bp_ready", {62'd0, m0_ready_o, m1_ready_o}, 64'd0);
            @(posedge clk); #1;
        end

        m0_valid_i         = 1'b0;
        m1_valid_i         = 1'b0;
        cache_resp_valid_i = 1'b0;
        cache_ready_i      = 1'b1;
        cache_rdata_i      = rdata;
        e.owner            = win;
        e.data             = rdata;
        if (lat < 0 && !rst_in_wait) begin
            cache_resp_valid_i = 1'b1;
            exp_rsp.push_back(e);
            @(posedge clk); #1;
            cache_ready_i      = 1'b0;
            cache_resp_valid_i = 1'b0;
            prio_m             = ~win;
        end else begin
            @(posedge clk); #1;
            cache_ready_i = 1'b0;
            for (int i = 0; i < lat; i++) begin
                m0_valid_i    = 1'($urandom_range(0, 1));
                m1_valid_i    = 1'($urandom_range(0, 1));
                cache_rdata_i = $urandom;
                @(posedge clk); #1;
            end
            m0_valid_i = 1'b0;
            m1_valid_i = 1'b0;
            if (rst_in_wait) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst    = 1'b0;
                prio_m = 1'b0;
                check("busy_after_reset", {63'd0, busy_o}, 64'd0);
                cache_resp_valid_i = 1'b1;   // abandoned response, must not reach a master
                cache_rdata_i      = rdata;
                @(posedge clk); #1;
                cache_resp_valid_i = 1'b0;
            end else begin
                cache_resp_valid_i = 1'b1;
                cache_rdata_i      = rdata;
                exp_rsp.push_back(e);
                @(posedge clk); #1;
                cache_resp_valid_i = 1'b0;
                prio_m             = ~win;
            end
        end
        check("idle_after_txn", {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        req_t ra, rb;
        logic [1:0] v;

        rst = 1'b1;
        m0_valid_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_wdata_i = '0;
        m1_valid_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_wdata_i = '0;
        cache_ready_i = 0; cache_resp_valid_i = 0; cache_rdata_i = '0;
        prio_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_cache_valid", {63'd0, cache_valid_o}, 64'd0);
        check("rst_busy",        {63'd0, busy_o}, 64'd0);
        check("rst_ready",       {62'd0, m0_ready_o, m1_ready_o}, 64'd0);
        check("rst_resp",        {62'd0, m0_resp_valid_o, m1_resp_valid_o}, 64'd0);
        check("rst_adr",         {48'd0, cache_adr_o}, 64'd0);

        // Single read: m0, adr 0x0010, ready at T+1, response at T+3.
        ra = '{owner: 1'b0, we: 1'b0, adr: 16'h0010, wdata: 32'h0};
        rb = rand_req();
        do_txn(1'b1, 1'b0, ra, rb, 0, 1, 32'hDEADBEEF, 1'b0);

        // Zero-latency write hit from m1.
        rb = '{owner: 1'b1, we: 1'b1, adr: 16'h0200, wdata: 32'h12345678};
        do_txn(1'b0, 1'b1, rand_req(), rb, 0, -1, 32'hA5A5A5A5, 1'b0);

        // Backpressure: five cycles with cache_ready_i low.
        do_txn(1'b1, 1'b0, rand_req(), rand_req(), 5, 2, $urandom, 1'b0);

        // Spurious response while idle.
        cache_resp_valid_i = 1'b1;
        cache_rdata_i      = $urandom;
        @(negedge clk);
        check("spurious_ready", {62'd0, m0_ready_o, m1_ready_o}, 64'd0);
        @(posedge clk); #1;
        cache_resp_valid_i = 1'b0;
        check("spurious_busy", {63'd0, busy_o}, 64'd0);

        // Contention: both requesting back-to-back.
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, rand_req(), rand_req(), 0, $urandom_range(0, 2) - 1, $urandom, 1'b0);
        end

        // Reset in WAIT: make the pointer favour m1 first, then abandon a txn.
        do_txn(1'b1, 1'b0, rand_req(), rand_req(), 0, 0, $urandom, 1'b0);
        do_txn(1'b1, 1'b0, rand_req(), rand_req(), 0, 2, $urandom, 1'b1);
        do_txn(1'b1, 1'b1, rand_req(), rand_req(), 0, 0, $urandom, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3));
            do_txn(v[0], v[1], rand_req(), rand_req(), $urandom_range(0, 3),
                   $urandom_range(0, 4) - 1, $urandom, 1'b0);
        end

        repeat (2) @(posedge clk);
        check("grant_queue_drained", 64'(exp_grant.size()), 64'd0);
        check("req_queue_drained",   64'(exp_req.size()),   64'd0);
        check("rsp_queue_drained",   64'(exp_rsp.size()),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
